fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the MIPS core, sitting directly upstream of decode (`maindec`/`regfile`). Owns the program counter, drives the instruction memory, and holds the IF/ID pipeline register that decode consumes. Computes branch and jump targets from the instruction in IF/ID, flushes the wrong-path fetch on a redirect, honours stalls from the hazard logic, and halts cleanly when the PC runs past the end of the loaded program.

## Interface
- `RESET_PC`, default 32'h0: byte address loaded into PC on reset.
- `PROG_DEPTH`, default 10: number of program words in instruction memory. Valid word indices are 0..PROG_DEPTH-1.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous, active-low. `rst`=0 resets the block.
- `stall`  in  1  from hazard logic. Freezes PC, IF/ID, FSM and counter.
- `branch_taken`  in  1  from decode. Branch in IF/ID resolves taken.
- `jump`  in  1  from decode. Instruction in IF/ID is J-type.
- `imem_data`  in  32  instruction word at `imem_addr`. Combinational, same cycle.
- `imem_addr`  out  32  word index into instruction memory, equal to {2'b00, pc_f[31:2]}.
- `pc_f`  out  32  current fetch PC, byte address.
- `instr_d`  out  32  IF/ID instruction.
- `pcplus4_d`  out  32  IF/ID PC+4.
- `valid_d`  out  1  IF/ID holds a real instruction. 0 means bubble.
- `halted`  out  1  FSM in HALT.
- `fetch_count`  out  32  number of instructions written into IF/ID with `valid_d`=1.

## Operation
- FSM states: RUN, HALT. Reset state is RUN.
- Redirect: `redirect = valid_d & (jump | branch_taken)`. `jump` has priority over `branch_taken`.
  - Branch target: `pcplus4_d + {{14{instr_d[15]}}, instr_d[15:0], 2'b00}`, mod 2^32.
  - Jump target: `{pcplus4_d[31:28], instr_d[25:0], 2'b00}`.
  - `jump`/`branch_taken` are ignored while `valid_d`=0.
- End of program: `eop = (pc_f[31:2] >= PROG_DEPTH)`, unsigned compare.
- Rising-edge update, evaluated in priority order:
  1. `stall`=1: all state holds, including PC, IF/ID, FSM and `fetch_count`. A redirect presented in this cycle is dropped; decode re-presents it.
  2. `redirect`: PC <= target. IF/ID <= bubble (`instr_d`=0, `pcplus4_d`=0, `valid_d`=0). State <= RUN, including exit from HALT. Counter holds.
  3. RUN and !`eop`: IF/ID <= {`imem_data`, `pc_f`+4, 1}. PC <= `pc_f`+4. `fetch_count`++.
  4. Otherwise (`eop`, or HALT): IF/ID <= bubble. PC holds. State <= HALT.
- No branch delay slot. A taken branch or jump costs exactly one bubble.
- `fetch_count` wraps from 32'hFFFFFFFF to 0.
- A redirect target at or beyond PROG_DEPTH is accepted. The next edge then enters HALT with no fetch.

## Timing
- Reset values (asynchronous, while `rst`=0): `pc_f`=RESET_PC, `instr_d`=0, `pcplus4_d`=0, `valid_d`=0, `halted`=0, `fetch_count`=0, state RUN.
- Reset mid-operation takes effect immediately, with no clock required, and discards any in-flight redirect.
- First edge after `rst` rises: the instruction at RESET_PC is in IF/ID.
- Fetch latency is 1 cycle: `imem_data` sampled at edge N appears on `instr_d` after edge N.
- Redirect penalty is 1 cycle: target instruction is in IF/ID two edges after the branch entered IF/ID.
- `halted` is registered and rises on the edge that first writes a bubble due to `eop`.
- Stall and redirect asserted together: stall wins.
- Stall in HALT: holds HALT.

## Test plan
- Straight line: reset, RESET_PC=0, PROG_DEPTH=10, memory words 0..9 = 32'h1000+i. Release reset -> `instr_d` = 32'h1000..32'h1009 on consecutive edges with `valid_d`=1. Next edge -> `halted`=1, `valid_d`=0, `pc_f`=40, `fetch_count`=10.
- Taken branch: word 2 has imm 16'hFFFE, decode asserts `branch_taken` while it sits in IF/ID -> target = 12 + (-8) = 4. Next IF/ID is a bubble, then word 1. `fetch_count` does not count the bubble.
- Jump: word 3 = J with index 26'h7, `jump`=1 and `branch_taken`=1 together -> PC=28 (jump wins), one bubble, then word 7.
- Stall: assert `stall` for 3 cycles mid-program with `branch_taken`=1 during the stall -> `pc_f`, `instr_d`, `fetch_count` unchanged and no redirect taken. On release, fetch resumes at the held PC.
- HALT exit: the last word (9) is a branch to word 0, taken. The redirect occurs on the same edge `eop` would be seen -> no HALT, PC=0, and words 0.. fetch again. Separately, a redirect while `halted`=1 -> `halted`=0 the next edge.
- Async reset: drop `rst` between edges mid-run -> all outputs reach reset values before the next edge. Also preload `fetch_count`=32'hFFFFFFFF via forced state -> one fetch wraps it to 0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, instruction-memory addressing and the IF/ID
// register. Handles branch/jump redirects, hazard stalls and the end-of-program halt.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned PROG_DEPTH = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic        jump,
    input  logic [31:0] imem_data,
    output logic [31:0] imem_addr,
    output logic [31:0] pc_f,
    output logic [31:0] instr_d,
    output logic [31:0] pcplus4_d,
    output logic        valid_d,
    output logic        halted,
    output logic [31:0] fetch_count
);
    localparam logic [31:0] DEPTH_W = 32'(PROG_DEPTH);

    typedef enum logic [0:0] {ST_RUN = 1'b0, ST_HALT = 1'b1} state_e;

    function automatic logic [31:0] branch_target(input logic [31:0] p4, input logic [31:0] ins);
        return p4 + {{14{ins[15]}}, ins[15:0], 2'b00};
    endfunction

    function automatic logic [31:0] jump_target(input logic [31:0] p4, input logic [31:0] ins);
        return {p4[31:28], ins[25:0], 2'b00};
    endfunction

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic        halted_q, halted_d;
    logic [31:0] count_q, count_d;

    logic        redirect_s;
    logic        eop_s;
    logic [31:0] target_s;

    // Redirect decode and end-of-program detect; jump outranks branch.
    always_comb begin
        redirect_s = ifid_valid_q & (jump | branch_taken);
        eop_s      = ({2'b00, pc_q[31:2]} >= DEPTH_W);
        if (jump) begin
            target_s = jump_target(ifid_pc4_q, ifid_instr_q);
        end else begin
            target_s = branch_target(ifid_pc4_q, ifid_instr_q);
        end
    end

    // Next-state selection for PC, IF/ID, FSM and fetch counter.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;
        count_d      = count_q;
        if (stall) begin
            // A redirect seen during a stall is dropped; decode re-presents it.
            state_d = state_q;
        end else if (redirect_s) begin
            pc_d         = target_s;
            ifid_instr_d = 32'h0000_0000;
            ifid_pc4_d   = 32'h0000_0000;
            ifid_valid_d = 1'b0;
            state_d      = ST_RUN;
        end else if ((state_q == ST_RUN) && !eop_s) begin
            pc_d         = pc_q + 32'd4;
            ifid_instr_d = imem_data;
            ifid_pc4_d   = pc_q + 32'd4;
            ifid_valid_d = 1'b1;
            count_d      = count_q + 32'd1;
            state_d      = ST_RUN;
        end else begin
            ifid_instr_d = 32'h0000_0000;
            ifid_pc4_d   = 32'h0000_0000;
            ifid_valid_d = 1'b0;
            state_d      = ST_HALT;
        end
        halted_d = (state_d == ST_HALT);
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_RUN;
            pc_q         <= RESET_PC;
            ifid_instr_q <= 32'h0000_0000;
            ifid_pc4_q   <= 32'h0000_0000;
            ifid_valid_q <= 1'b0;
            halted_q     <= 1'b0;
            count_q      <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
            halted_q     <= halted_d;
            count_q      <= count_d;
        end
    end

    assign imem_addr   = {2'b00, pc_q[31:2]};
    assign pc_f        = pc_q;
    assign instr_d     = ifid_instr_q;
    assign pcplus4_d   = ifid_pc4_q;
    assign valid_d     = ifid_valid_q;
    assign halted      = halted_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized run
// against a behavioural model of the fetch/redirect/halt rules.
module tb_fetch_stage;
    localparam int DEPTH = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic        jump;
    logic [31:0] imem_data;
    logic [31:0] imem_addr;
    logic [31:0] pc_f;
    logic [31:0] instr_d;
    logic [31:0] pcplus4_d;
    logic        valid_d;
    logic        halted;
    logic [31:0] fetch_count;

    logic [31:0] mem [0:63];

    int n_total = 0;
    int n_pass  = 0;

    // Reference model state
    logic [31:0] m_pc, m_instr, m_p4, m_count;
    logic        m_valid, m_halt;

    fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .branch_taken(branch_taken),
        .jump        (jump),
        .imem_data   (imem_data),
        .imem_addr   (imem_addr),
        .pc_f        (pc_f),
        .instr_d     (instr_d),
        .pcplus4_d   (pcplus4_d),
        .valid_d     (valid_d),
        .halted      (halted),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    assign imem_data = (imem_addr < 32'd64) ? mem[imem_addr[5:0]] : {16'hBAD0, imem_addr[15:0]};

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_p4 = 32'h0; m_valid = 1'b0; m_halt = 1'b0; m_count = 32'h0;
    endtask

    task automatic model_edge();
        int off;
        if (!rst) begin
            model_reset();
        end else if (!stall) begin
            if (m_valid && (jump || branch_taken)) begin
                if (jump) begin
                    m_pc = {m_p4[31:28], m_instr[25:0], 2'b00};
                end else begin
                    off  = int'($signed(m_instr[15:0]));
                    m_pc = m_p4 + 32'(off * 4);
                end
                m_instr = 32'h0; m_p4 = 32'h0; m_valid = 1'b0; m_halt = 1'b0;
            end else if (!m_halt && ((m_pc / 4) < DEPTH)) begin
                m_instr = mem[m_pc[7:2]];
                m_p4    = m_pc + 32'd4;
                m_pc    = m_pc + 32'd4;
                m_valid = 1'b1;
                m_count = m_count + 32'd1;
            end else begin
                m_instr = 32'h0; m_p4 = 32'h0; m_valid = 1'b0; m_halt = 1'b1;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic load_linear();
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000 + 32'(i);
    endtask

    task automatic restart();
        rst = 1'b0;
        model_reset();
        cycle();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
        load_linear();
        model_reset();
        #3;
        n_total++;
        if ({pc_f, instr_d, pcplus4_d, valid_d, halted, fetch_count} !== {32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0})
            $display("FAIL reset_state: got pc=%h ins=%h p4=%h v=%b h=%b cnt=%h", pc_f, instr_d, pcplus4_d, valid_d, halted, fetch_count);
        else n_pass++;
        n_total++;
        if (imem_addr !== 32'h0) $display("FAIL reset_imem_addr: got %h want 0", imem_addr);
        else n_pass++;
        cycle();
        rst = 1'b1;
    endtask

    task automatic test_straight_line();
        for (int i = 0; i < 10; i++) begin
            cycle();
            n_total++;
            if (instr_d !== 32'h1000 + 32'(i) || valid_d !== 1'b1)
                $display("FAIL straight_word%0d: got ins=%h v=%b want ins=%h v=1", i, instr_d, valid_d, 32'h1000 + 32'(i));
            else n_pass++;
        end
        cycle();
        n_total++;
        if ({halted, valid_d, pc_f, fetch_count} !== {1'b1, 1'b0, 32'd40, 32'd10})
            $display("FAIL straight_halt: got h=%b v=%b pc=%0d cnt=%0d want h=1 v=0 pc=40 cnt=10", halted, valid_d, pc_f, fetch_count);
        else n_pass++;
        stall = 1'b1;
        cycle();
        stall = 1'b0;
        n_total++;
        if (halted !== 1'b1 || pc_f !== 32'd40) $display("FAIL stall_in_halt: got h=%b pc=%0d want h=1 pc=40", halted, pc_f);
        else n_pass++;
        jump = 1'b1;
        cycle();
        jump = 1'b0;
        n_total++;
        if (halted !== 1'b1 || pc_f !== 32'd40) $display("FAIL jump_ignored_halt: got h=%b pc=%0d want h=1 pc=40", halted, pc_f);
        else n_pass++;
    endtask

    task automatic test_branch();
        load_linear();
        mem[2] = 32'h1000_FFFE;
        restart();
        repeat (3) cycle();
        branch_taken = 1'b1;
        cycle();
        branch_taken = 1'b0;
        n_total++;
        if ({valid_d, pc_f, fetch_count} !== {1'b0, 32'd4, 32'd3})
            $display("FAIL branch_bubble: got v=%b pc=%0d cnt=%0d want v=0 pc=4 cnt=3", valid_d, pc_f, fetch_count);
        else n_pass++;
        cycle();
        n_total++;
        if ({instr_d, pcplus4_d, valid_d, fetch_count} !== {32'h1001, 32'd8, 1'b1, 32'd4})
            $display("FAIL branch_target: got ins=%h p4=%0d v=%b cnt=%0d want ins=1001 p4=8 v=1 cnt=4", instr_d, pcplus4_d, valid_d, fetch_count);
        else n_pass++;
    endtask

    task automatic test_jump();
        load_linear();
        mem[3] = 32'h0800_0007;
        restart();
        repeat (4) cycle();
        jump = 1'b1; branch_taken = 1'b1;
        cycle();
        jump = 1'b0; branch_taken = 1'b0;
        n_total++;
        if (pc_f !== 32'd28 || valid_d !== 1'b0) $display("FAIL jump_pc: got pc=%0d v=%b want pc=28 v=0", pc_f, valid_d);
        else n_pass++;
        cycle();
        n_total++;
        if (instr_d !== 32'h1007 || pcplus4_d !== 32'd32) $display("FAIL jump_target: got ins=%h p4=%0d want ins=1007 p4=32", instr_d, pcplus4_d);
        else n_pass++;
    endtask

    task automatic test_stall();
        load_linear();
        restart();
        repeat (5) cycle();
        stall = 1'b1; branch_taken = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            n_total++;
            if ({pc_f, instr_d, fetch_count} !== {32'd20, 32'h1004, 32'd5})
                $display("FAIL stall_hold%0d: got pc=%0d ins=%h cnt=%0d want pc=20 ins=1004 cnt=5", k, pc_f, instr_d, fetch_count);
            else n_pass++;
        end
        stall = 1'b0; branch_taken = 1'b0;
        cycle();
        n_total++;
        if (instr_d !== 32'h1005 || pc_f !== 32'd24) $display("FAIL stall_resume: got ins=%h pc=%0d want ins=1005 pc=24", instr_d, pc_f);
        else n_pass++;
    endtask

    task automatic test_halt_exit();
        load_linear();
        mem[9] = 32'h1000_FFF6;
        restart();
        repeat (10) cycle();
        branch_taken = 1'b1;
        cycle();
        branch_taken = 1'b0;
        n_total++;
        if ({halted, pc_f, valid_d} !== {1'b0, 32'd0, 1'b0})
            $display("FAIL halt_exit_redirect: got h=%b pc=%0d v=%b want h=0 pc=0 v=0", halted, pc_f, valid_d);
        else n_pass++;
        cycle();
        n_total++;
        if (instr_d !== 32'h1000 || valid_d !== 1'b1 || halted !== 1'b0)
            $display("FAIL halt_exit_refetch: got ins=%h v=%b h=%b want ins=1000 v=1 h=0", instr_d, valid_d, halted);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        load_linear();
        mem[2] = 32'h1000_0005;
        restart();
        repeat (3) cycle();
        branch_taken = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        n_total++;
        if ({pc_f, instr_d, pcplus4_d, valid_d, halted, fetch_count} !== {32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0})
            $display("FAIL async_reset: got pc=%h ins=%h p4=%h v=%b h=%b cnt=%h", pc_f, instr_d, pcplus4_d, valid_d, halted, fetch_count);
        else n_pass++;
        branch_taken = 1'b0;
        cycle();
        rst = 1'b1;
        cycle();
        n_total++;
        if (instr_d !== 32'h1000 || pc_f !== 32'd4) $display("FAIL async_reset_restart: got ins=%h pc=%0d want ins=1000 pc=4", instr_d, pc_f);
        else n_pass++;
        dut.count_q = 32'hFFFF_FFFF;
        m_count     = 32'hFFFF_FFFF;
        cycle();
        n_total++;
        if (fetch_count !== 32'h0) $display("FAIL count_wrap: got %h want 00000000", fetch_count);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [15:0] imm;
        for (int i = 0; i < 64; i++) begin
            imm    = 16'(int'($urandom_range(0, 24)) - 12);
            mem[i] = {6'($urandom), (($urandom % 2) == 0) ? 10'h000 : 10'($urandom), imm};
        end
        restart();
        for (int c = 0; c < 400; c++) begin
            stall        = ($urandom % 5) == 0;
            branch_taken = ($urandom % 5) == 0;
            jump         = ($urandom % 8) == 0;
            rst          = !((($urandom % 40) == 0) || (m_halt && (($urandom % 4) == 0)));
            cycle();
            n_total++;
            if ({pc_f, instr_d, pcplus4_d, valid_d, halted, fetch_count, imem_addr} !==
                {m_pc, m_instr, m_p4, m_valid, m_halt, m_count, {2'b00, m_pc[31:2]}})
                $display("FAIL random_c%0d: got pc=%h ins=%h p4=%h v=%b h=%b cnt=%0d want pc=%h ins=%h p4=%h v=%b h=%b cnt=%0d",
                         c, pc_f, instr_d, pcplus4_d, valid_d, halted, fetch_count, m_pc, m_instr, m_p4, m_valid, m_halt, m_count);
            else n_pass++;
        end
        stall = 1'b0; branch_taken = 1'b0; jump = 1'b0; rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_straight_line();
        test_branch();
        test_jump();
        test_stall();
        test_halt_exit();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
